// File: rtl/calc_keypad_scan_if.sv
// Command strobe bundle from the keypad scanner to the calculator core.
interface calc_keypad_scan_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       key_held;

  modport master (output cmd, output cmd_valid, output key_held);
  modport slave  (input  cmd, input  cmd_valid, input  key_held);
endinterface

// File: rtl/calc_keypad_scan.sv
// 4x4 active-low keypad scanner with debounce; one-cycle command strobe per accepted press.
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module calc_keypad_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter logic [3:0]  IDLE_CODE      = 4'b1111,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         col_n,
  output logic [3:0]         row_n,
  calc_keypad_scan_if.master cmd_if
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_V      = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam bit            DB_ONE    = (DEBOUNCE_SCANS == 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("calc_keypad_scan: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("calc_keypad_scan: DEBOUNCE_SCANS must be >= 1");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("calc_keypad_scan: REPEAT_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  logic [3:0]    col_s1, col_s2;
  logic [SW-1:0] slot;
  logic [1:0]    row;
  logic [3:0]    row_q;
  logic          slot_last, scan_end;

  // Hits accumulated over rows 0..2 of the current scan; count saturates at 2 (MULTI).
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_key;
  logic [1:0]    row_cnt;
  logic [1:0]    row_col;
  logic [2:0]    sum_cnt;
  logic [1:0]    tot_cnt;
  logic [3:0]    tot_key;
  logic          is_none, is_single;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    cand, cand_nx;
  logic          strobe, rep_fire, strobe_all;

  logic [3:0]    cmd_q;
  logic          valid_q, held_q;

  assign slot_last = (slot == SLOT_LAST);
  assign scan_end  = slot_last && (row == 2'd3);
  assign row_n     = row_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_s1  <= '1;
      col_s2  <= '1;
      slot    <= '0;
      row     <= '0;
      row_q   <= 4'b1110;
      acc_cnt <= '0;
      acc_key <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (slot_last) begin
        slot  <= '0;
        row   <= row + 2'd1;
        row_q <= {row_q[2:0], row_q[3]};
        if (scan_end) begin
          acc_cnt <= '0;
          acc_key <= '0;
        end else begin
          acc_cnt <= tot_cnt;
          acc_key <= tot_key;
        end
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // Column sample of the current row merged with earlier rows; only consumed in a slot's last cycle.
  always_comb begin
    row_cnt = '0;
    row_col = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
        row_col = 2'(c);
      end
    end
    sum_cnt   = {1'b0, acc_cnt} + {1'b0, row_cnt};
    tot_cnt   = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    tot_key   = (row_cnt != 2'd0) ? {row, row_col} : acc_key;
    is_none   = (tot_cnt == 2'd0);
    is_single = (tot_cnt == 2'd1);
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    strobe   = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (is_single) begin
            cand_nx = tot_key;
            if (DB_ONE) begin
              strobe   = 1'b1;
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx   = CNT_ONE;
              state_nx = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (is_single && (tot_key == cand)) begin
            if (cnt_inc >= DB_V) begin
              strobe   = 1'b1;
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else if (is_single) begin
            cand_nx = tot_key;
            cnt_nx  = CNT_ONE;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        HELD: begin
          if (is_none) begin
            if (DB_ONE) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = RELEASE_DB;
              cnt_nx   = CNT_ONE;
            end
          end
        end
        RELEASE_DB: begin
          if (is_none) begin
            if (cnt_inc >= DB_V) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = HELD;
            cnt_nx   = '0;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_V = RW'(REPEAT_SCANS);

  logic [RW-1:0] rep, rep_nx, rep_inc;

  assign rep_inc = rep + RW'(1);

  // Only scans seen while already in HELD count; any other scan (including the one entering HELD) clears.
  always_comb begin
    rep_nx   = rep;
    rep_fire = 1'b0;
    if (scan_end) begin
      if ((state == HELD) && is_single && (tot_key == cand)) begin
        if (rep_inc >= REP_V) begin
          rep_fire = 1'b1;
          rep_nx   = '0;
        end else begin
          rep_nx = rep_inc;
        end
      end else begin
        rep_nx = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rep <= '0;
    else        rep <= rep_nx;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign strobe_all = strobe | rep_fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q   <= IDLE_CODE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      cmd_q   <= strobe_all ? cand_nx : IDLE_CODE;
      valid_q <= strobe_all;
      held_q  <= (state_nx == HELD) || (state_nx == RELEASE_DB);
    end
  end

  assign cmd_if.cmd       = cmd_q;
  assign cmd_if.cmd_valid = valid_q;
  assign cmd_if.key_held  = held_q;

endmodule

// File: tb/tb_calc_keypad_scan.sv
// Bench for calc_keypad_scan: timeline model of the keypad scan plus directed and random key activity.
`timescale 1ns/1ps
module tb_calc_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] pressed = '0;

  calc_keypad_scan_if kif ();

  calc_keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB),
    .IDLE_CODE(4'hF),
    .REPEAT_SCANS(RS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .col_n(col_n),
    .row_n(row_n),
    .cmd_if(kif)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[4*r+c]) col_n[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycle n after reset is in row (n/SD)%4; the slot's last cycle samples keys as they were at n-2.
  int          cyc = 0;
  int          mcyc = 0;
  logic [15:0] h0 = '0, h1 = '0, h2 = '0;
  int          acc_n = 0, acc_k = 0;
  int          m_cand = 0, m_run = 0, m_rep = 0;
  bit          m_held = 0;
  logic [3:0]  e_row = 4'b1110, e_cmd = 4'hF;
  bit          e_valid = 0, e_held = 0;

  initial forever begin
    bit strobe;
    int r;
    @(posedge clock);
    cyc++;
    strobe = 0;
    if (!reset) begin
      mcyc = 0; h0 = '0; h1 = '0; h2 = '0; acc_n = 0; acc_k = 0;
      m_cand = 0; m_run = 0; m_rep = 0; m_held = 0;
      e_row = 4'b1110;
    end else begin
      h2 = h1; h1 = h0; h0 = pressed;
      if (mcyc % SD == SD - 1) begin
        r = (mcyc / SD) % 4;
        for (int c = 0; c < 4; c++)
          if (h2[4*r+c]) begin acc_n++; acc_k = 4*r + c; end
        if (r == 3) begin
          if (!m_held) begin
            if (acc_n == 1) begin
              if (m_run > 0 && acc_k == m_cand) m_run++;
              else begin m_cand = acc_k; m_run = 1; end
              if (m_run >= DB) begin strobe = 1; m_held = 1; m_run = 0; m_rep = 0; end
            end else m_run = 0;
          end else if (acc_n == 0) begin
            m_run++;
            m_rep = 0;
            if (m_run >= DB) begin m_held = 0; m_run = 0; end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (m_run > 0) m_rep = 0;
            else if (acc_n == 1 && acc_k == m_cand) begin
              m_rep++;
              if (m_rep == RS) begin strobe = 1; m_rep = 0; end
            end else m_rep = 0;
`endif
            m_run = 0;
          end
          acc_n = 0;
        end
      end
      mcyc++;
      e_row = ~(4'b0001 << ((mcyc / SD) % 4));
    end
    e_valid = strobe;
    e_cmd   = strobe ? 4'(m_cand) : 4'hF;
    e_held  = m_held;
  end

  int npulse = 0;
  int last_cmd = -1;
  int last_pulse_cyc = 0;

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("rst_row_n", row_n, 4'b1110);
      chk("rst_cmd", kif.cmd, 4'hF);
      chk("rst_cmd_valid", kif.cmd_valid, 0);
      chk("rst_key_held", kif.key_held, 0);
    end else begin
      chk("row_n", row_n, e_row);
      chk("cmd", kif.cmd, e_cmd);
      chk("cmd_valid", kif.cmd_valid, e_valid);
      chk("key_held", kif.key_held, e_held);
      if (kif.cmd_valid) begin
        npulse++;
        last_cmd = kif.cmd;
        last_pulse_cyc = cyc;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int p, c0, lat, prev, gap_bad;
    step(5);
    chk("reset_row_n", row_n, 4'b1110);
    chk("reset_cmd", kif.cmd, 4'hF);
    chk("reset_valid", kif.cmd_valid, 0);
    chk("reset_held", kif.key_held, 0);
    reset = 1'b1;
    step(4);
    chk("row1_after_4", row_n, 4'b1101);
    step(4);
    chk("row2_after_8", row_n, 4'b1011);
    step(24);

`ifndef KEYPAD_REPEAT_EN
    // Key 6 (row 1, col 2) held for 200 cycles.
    p = npulse; c0 = cyc; lat = -1; pressed = 16'h0040;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (npulse > p && lat < 0) lat = last_pulse_cyc - c0;
    end
    chk("press6_latency_ok", int'(lat >= 0 && lat <= 67), 1);
    step(120);
    chk("press6_pulses", npulse - p, 1);
    chk("press6_cmd", last_cmd, 6);
    chk("press6_held", kif.key_held, 1);
    pressed = '0;
    step(80);
    chk("press6_released", kif.key_held, 0);

    // Key 8 bouncing every 5 cycles, then stable.
    p = npulse;
    for (int i = 0; i < 12; i++) begin
      pressed = pressed ^ 16'h0100;
      step(5);
    end
    chk("bounce_no_pulse", npulse - p, 0);
    pressed = 16'h0100;
    step(100);
    chk("bounce_pulses", npulse - p, 1);
    chk("bounce_cmd", last_cmd, 8);
    pressed = '0;
    step(80);

    // Keys 0 and 5 together.
    p = npulse; pressed = 16'h0021;
    step(200);
    chk("multi_no_pulse", npulse - p, 0);
    chk("multi_not_held", kif.key_held, 0);
    pressed = '0;
    step(20);

    // Key 3: one-scan release glitch, then a real release.
    p = npulse; pressed = 16'h0008;
    step(100);
    chk("key3_first", npulse - p, 1);
    chk("key3_cmd", last_cmd, 3);
    pressed = '0;
    step(16);
    pressed = 16'h0008;
    step(80);
    chk("key3_glitch_no_pulse", npulse - p, 1);
    chk("key3_still_held", kif.key_held, 1);
    pressed = '0;
    step(64);
    pressed = 16'h0008;
    step(100);
    chk("key3_second", npulse - p, 2);
    chk("key3_second_cmd", last_cmd, 3);
    pressed = '0;
    step(80);
`else
    // Key 15 held: repeats every RS scans.
    p = npulse; prev = -1; gap_bad = 0; pressed = 16'h8000;
    for (int i = 0; i < 320; i++) begin
      lat = npulse;
      step(1);
      if (npulse > lat) begin
        if (prev >= 0 && last_pulse_cyc - prev != 64) gap_bad++;
        prev = last_pulse_cyc;
      end
    end
    chk("repeat_count_ge3", int'(npulse - p >= 3), 1);
    chk("repeat_gap_errors", gap_bad, 0);
    pressed = '0;
    step(80);
`endif

    // Key 15, reset after two scans.
    p = npulse; pressed = 16'h8000;
    step(32);
    reset = 1'b0;
    step(3);
    chk("middb_no_pulse", npulse - p, 0);
    chk("middb_row_n", row_n, 4'b1110);
    chk("middb_cmd", kif.cmd, 4'hF);
    chk("middb_held", kif.key_held, 0);
    pressed = '0;
    reset = 1'b1;
    step(40);

    for (int it = 0; it < 50; it++) begin
      int mode, dur, k1, k2, per;
      mode = $urandom_range(0, 3);
      dur  = $urandom_range(10, 160);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      case (mode)
        0: begin pressed = 16'(1 << k1); step(dur); end
        1: begin pressed = 16'((1 << k1) | (1 << k2)); step(dur); end
        2: begin
          per = $urandom_range(1, 8);
          for (int t = 0; t < dur; t += per) begin
            pressed = pressed ^ 16'(1 << k1);
            step(per);
          end
        end
        default: step(dur);
      endcase
      pressed = '0;
      step($urandom_range(0, 80));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        step(2);
        reset = 1'b1;
      end
    end
    step(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
